// File: rtl/me_ref_fetch_sched_pkg.sv
// Shared types and default geometry for the ME reference fetch scheduler.
package me_ref_fetch_sched_pkg;

  localparam int NUM_COLS_DEF = 32;
  localparam int ROWS_DEF     = 64;
  localparam int ROW_W_DEF    = 6;
  localparam int COL_W_DEF    = 5;
  localparam int DATA_W_DEF   = 256;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRIME     = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_FILL = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/me_ref_fetch_sched_fill_tracker.sv
// DMA refill tracker: owns the req/gnt handshake for one outstanding refill,
// counts row beats into the target bank and flags the last beat.
module me_ref_fetch_sched_fill_tracker
  import me_ref_fetch_sched_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int ROW_W  = ROW_W_DEF,
  parameter int COL_W  = COL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_issue,
  input  logic [COL_W-1:0]  i_issue_col,
  input  logic              i_issue_bank,
  input  logic              i_refill_gnt,
  input  logic              i_refill_valid,
  input  logic [DATA_W-1:0] i_refill_data,
  output logic              o_refill_req,
  output logic [COL_W-1:0]  o_refill_col,
  output logic              o_refill_wr_en,
  output logic [ROW_W:0]    o_refill_wr_addr,
  output logic [DATA_W-1:0] o_refill_wr_data,
  output logic              o_fill_done,
  output logic              o_fill_bank
);

  logic              r_req;
  logic [COL_W-1:0]  r_col;
  logic              r_bank;
  logic              r_active;
  logic [ROW_W-1:0]  r_cnt;
  logic              r_wr_en;
  logic [ROW_W:0]    r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic w_beat;
  logic w_last;

  // Beats only count once the DMA has granted; strays are dropped.
  assign w_beat = r_active & i_refill_valid;
  assign w_last = w_beat && (r_cnt == ROW_W'(ROWS - 1));

  // Handshake, beat counting and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req     <= 1'b0;
      r_col     <= '0;
      r_bank    <= 1'b0;
      r_active  <= 1'b0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_beat;
      if (w_beat) begin
        r_wr_addr <= {r_bank, r_cnt};
        r_wr_data <= i_refill_data;
        r_cnt     <= w_last ? '0 : r_cnt + ROW_W'(1);
      end
      if (w_last) begin
        r_active <= 1'b0;
      end
      if (r_req && i_refill_gnt) begin
        r_req    <= 1'b0;
        r_active <= 1'b1;
      end
      // A new issue may land on the same edge as the previous last beat;
      // that beat's address was already taken from the old bank above.
      if (i_issue) begin
        r_req  <= 1'b1;
        r_col  <= i_issue_col;
        r_bank <= i_issue_bank;
      end
    end
  end

  assign o_refill_req     = r_req;
  assign o_refill_col     = r_col;
  assign o_refill_wr_en   = r_wr_en;
  assign o_refill_wr_addr = r_wr_addr;
  assign o_refill_wr_data = r_wr_data;
  assign o_fill_done      = w_last;
  assign o_fill_bank      = r_bank;

endmodule

// File: rtl/me_ref_fetch_sched.sv
// ME reference fetch scheduler: ping-pong reference banks, row reads paced by
// the PE controller, background refill of the idle bank from the DMA.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for start
//  PRIME     | first column loading into bank 0, PE array stalled
//  RUN       | serving reads from the active bank, idle bank refilling
//  WAIT_FILL | active column finished, next column not resident, stalled
//  DONE      | last column consumed, one-cycle done pulse
module me_ref_fetch_sched
  import me_ref_fetch_sched_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int ROW_W    = ROW_W_DEF,
  parameter int COL_W    = COL_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_change_ref,
  input  logic              i_col_done,
  output logic              o_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ref_rd_en,
  output logic [ROW_W:0]    o_ref_rd_addr,
  output logic              o_refill_req,
  output logic [COL_W-1:0]  o_refill_col,
  input  logic              i_refill_gnt,
  input  logic              i_refill_valid,
  input  logic [DATA_W-1:0] i_refill_data,
  output logic              o_refill_wr_en,
  output logic [ROW_W:0]    o_refill_wr_addr,
  output logic [DATA_W-1:0] o_refill_wr_data
);

  state_e           r_state, w_state_nxt;
  logic [COL_W-1:0] r_col_idx, w_col_idx_nxt;
  logic             r_rd_bank, w_rd_bank_nxt;
  logic [ROW_W-1:0] r_row_ptr, w_row_ptr_nxt;
  logic [1:0]       r_bank_valid, w_bank_valid_nxt;
  logic             r_rd_en, w_rd_en_nxt;
  logic [ROW_W:0]   r_rd_addr, w_rd_addr_nxt;
  logic             r_stall, r_busy, r_done;

  logic             w_issue;
  logic [COL_W-1:0] w_issue_col;
  logic             w_issue_bank;
  logic             w_fill_done;
  logic             w_fill_bank;
  logic             w_swap;
  logic             w_other_ready;
  logic             w_last_col;
  logic [COL_W:0]   w_col_plus2;
  logic             w_more_cols;

  // The other bank counts as resident if its last beat lands this cycle.
  assign w_other_ready = r_bank_valid[~r_rd_bank] | (w_fill_done && (w_fill_bank == ~r_rd_bank));
  assign w_last_col    = (r_col_idx == COL_W'(NUM_COLS - 1));
  assign w_col_plus2   = {1'b0, r_col_idx} + (COL_W+1)'(2);
  assign w_more_cols   = (w_col_plus2 < (COL_W+1)'(NUM_COLS));

  // Next-state, read pointer, bank flags and refill issue.
  always_comb begin
    w_state_nxt      = r_state;
    w_col_idx_nxt    = r_col_idx;
    w_rd_bank_nxt    = r_rd_bank;
    w_row_ptr_nxt    = r_row_ptr;
    w_bank_valid_nxt = r_bank_valid;
    w_rd_en_nxt      = 1'b0;
    w_rd_addr_nxt    = r_rd_addr;
    w_issue          = 1'b0;
    w_issue_col      = '0;
    w_issue_bank     = 1'b0;
    w_swap           = 1'b0;

    if (w_fill_done) begin
      w_bank_valid_nxt[w_fill_bank] = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_issue       = 1'b1;
          w_col_idx_nxt = '0;
          w_rd_bank_nxt = 1'b0;
          w_row_ptr_nxt = '0;
          w_state_nxt   = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (w_fill_done) begin
          if (NUM_COLS > 1) begin
            w_issue      = 1'b1;
            w_issue_col  = COL_W'(1);
            w_issue_bank = 1'b1;
          end
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_col_done) begin
          if (w_last_col) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_bank_valid_nxt[r_rd_bank] = 1'b0;
            if (w_other_ready) begin
              w_swap = 1'b1;
            end else begin
              w_state_nxt = ST_WAIT_FILL;
            end
          end
        end else if (i_change_ref) begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = {r_rd_bank, r_row_ptr};
          w_row_ptr_nxt = (r_row_ptr == ROW_W'(ROWS - 1)) ? '0 : r_row_ptr + ROW_W'(1);
        end
      end
      ST_WAIT_FILL: begin
        if (w_fill_done && (w_fill_bank == ~r_rd_bank)) begin
          w_swap = 1'b1;
        end
      end
      ST_DONE: begin
        w_bank_valid_nxt = '0;
        w_state_nxt      = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Move to the freshly filled bank and refill the one just released.
    if (w_swap) begin
      w_rd_bank_nxt = ~r_rd_bank;
      w_col_idx_nxt = r_col_idx + COL_W'(1);
      w_row_ptr_nxt = '0;
      w_state_nxt   = ST_RUN;
      if (w_more_cols) begin
        w_issue      = 1'b1;
        w_issue_col  = w_col_plus2[COL_W-1:0];
        w_issue_bank = r_rd_bank;
      end
    end
  end

  // State and datapath registers; status outputs registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_col_idx    <= '0;
      r_rd_bank    <= 1'b0;
      r_row_ptr    <= '0;
      r_bank_valid <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_stall      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_col_idx    <= w_col_idx_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_row_ptr    <= w_row_ptr_nxt;
      r_bank_valid <= w_bank_valid_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_rd_addr    <= w_rd_addr_nxt;
      r_stall      <= (w_state_nxt == ST_PRIME) || (w_state_nxt == ST_WAIT_FILL);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= (w_state_nxt == ST_DONE);
    end
  end

  me_ref_fetch_sched_fill_tracker #(
    .ROWS   (ROWS),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .DATA_W (DATA_W)
  ) u_fill (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_issue          (w_issue),
    .i_issue_col      (w_issue_col),
    .i_issue_bank     (w_issue_bank),
    .i_refill_gnt     (i_refill_gnt),
    .i_refill_valid   (i_refill_valid),
    .i_refill_data    (i_refill_data),
    .o_refill_req     (o_refill_req),
    .o_refill_col     (o_refill_col),
    .o_refill_wr_en   (o_refill_wr_en),
    .o_refill_wr_addr (o_refill_wr_addr),
    .o_refill_wr_data (o_refill_wr_data),
    .o_fill_done      (w_fill_done),
    .o_fill_bank      (w_fill_bank)
  );

  assign o_stall       = r_stall;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_ref_rd_en   = r_rd_en;
  assign o_ref_rd_addr = r_rd_addr;

endmodule

// File: tb/tb_me_ref_fetch_sched.sv
// Scoreboard bench for me_ref_fetch_sched with a 4-column search window.
module tb_me_ref_fetch_sched;

  localparam int NC = 4;
  localparam int RW = 6;
  localparam int CW = 2;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_change_ref, i_col_done;
  logic          o_stall, o_busy, o_done, o_ref_rd_en;
  logic [RW:0]   o_ref_rd_addr;
  logic          o_refill_req;
  logic [CW-1:0] o_refill_col;
  logic          i_refill_gnt, i_refill_valid;
  logic [DW-1:0] i_refill_data;
  logic          o_refill_wr_en;
  logic [RW:0]   o_refill_wr_addr;
  logic [DW-1:0] o_refill_wr_data;

  typedef struct {
    logic [RW:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         q_wr[$];
  logic [RW:0] q_rd[$];
  int          q_req[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_req = 0;
  int n_done = 0;
  logic prev_req = 1'b0;

  me_ref_fetch_sched #(
    .NUM_COLS (NC),
    .ROWS     (64),
    .ROW_W    (RW),
    .COL_W    (CW),
    .DATA_W   (DW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (i_start),
    .i_change_ref     (i_change_ref),
    .i_col_done       (i_col_done),
    .o_stall          (o_stall),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_ref_rd_en      (o_ref_rd_en),
    .o_ref_rd_addr    (o_ref_rd_addr),
    .o_refill_req     (o_refill_req),
    .o_refill_col     (o_refill_col),
    .i_refill_gnt     (i_refill_gnt),
    .i_refill_valid   (i_refill_valid),
    .i_refill_data    (i_refill_data),
    .o_refill_wr_en   (o_refill_wr_en),
    .o_refill_wr_addr (o_refill_wr_addr),
    .o_refill_wr_data (o_refill_wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int c, input int r);
    logic [DW-1:0] d;
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = {8'(c * 16 + i), 8'(r)};
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, hold off `dly` cycles, then grant once.
  task automatic grant(input int dly);
    int k = 0;
    while (o_refill_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("req_seen", 32'(o_refill_req), 1);
    repeat (dly) tick();
    chk("req_held", 32'(o_refill_req), 1);
    i_refill_gnt = 1'b1;
    tick();
    i_refill_gnt = 1'b0;
    chk("req_drop", 32'(o_refill_req), 0);
  endtask

  task automatic fill(input int col, input int bank, input int first, input int n);
    wr_t e;
    for (int r = first; r < first + n; r++) begin
      i_refill_valid = 1'b1;
      i_refill_data  = mk(col, r);
      e.addr = 7'(bank * 64 + r);
      e.data = mk(col, r);
      q_wr.push_back(e);
      tick();
    end
    i_refill_valid = 1'b0;
  endtask

  task automatic rd(input int n, input int bank, input int row0);
    for (int i = 0; i < n; i++) begin
      i_change_ref = 1'b1;
      q_rd.push_back(7'(bank * 64 + ((row0 + i) % 64)));
      tick();
    end
    i_change_ref = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(o_stall), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_rd_en"}, 32'(o_ref_rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(o_ref_rd_addr), 0);
    chk({tag, "_req"}, 32'(o_refill_req), 0);
    chk({tag, "_col"}, 32'(o_refill_col), 0);
    chk({tag, "_wr_en"}, 32'(o_refill_wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(o_refill_wr_addr), 0);
    chk({tag, "_wr_data_nz"}, 32'(|o_refill_wr_data), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, read or new request.
  always @(negedge clk) begin
    wr_t         e;
    logic [RW:0] a;
    int          c;
    if (o_refill_wr_en) begin
      n_wr++;
      n_checks++;
      if (q_wr.size() == 0) begin
        n_errors++;
        $display("FAIL wr_unexpected addr=%0d t=%0t", o_refill_wr_addr, $time);
      end else begin
        e = q_wr.pop_front();
        if (o_refill_wr_addr !== e.addr || o_refill_wr_data !== e.data) begin
          n_errors++;
          $display("FAIL wr addr got=%0d exp=%0d data_ok=%0d t=%0t",
                   o_refill_wr_addr, e.addr, (o_refill_wr_data === e.data), $time);
        end
      end
    end
    if (o_ref_rd_en) begin
      n_checks++;
      if (q_rd.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected addr=%0d t=%0t", o_ref_rd_addr, $time);
      end else begin
        a = q_rd.pop_front();
        if (o_ref_rd_addr !== a) begin
          n_errors++;
          $display("FAIL rd addr got=%0d exp=%0d t=%0t", o_ref_rd_addr, a, $time);
        end
      end
    end
    if (o_refill_req && !prev_req) begin
      n_req++;
      n_checks++;
      if (q_req.size() == 0) begin
        n_errors++;
        $display("FAIL req_unexpected col=%0d t=%0t", o_refill_col, $time);
      end else begin
        c = q_req.pop_front();
        if (32'(o_refill_col) !== c) begin
          n_errors++;
          $display("FAIL req col got=%0d exp=%0d t=%0t", o_refill_col, c, $time);
        end
      end
    end
    if (o_done) n_done++;
    prev_req = o_refill_req;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    i_start        = 1'b0;
    i_change_ref   = 1'b0;
    i_col_done     = 1'b0;
    i_refill_gnt   = 1'b0;
    i_refill_valid = 1'b0;
    i_refill_data  = '0;
    repeat (3) tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Stray beats in IDLE must not write.
    i_refill_valid = 1'b1;
    i_refill_data  = mk(9, 9);
    repeat (4) tick();
    i_refill_valid = 1'b0;
    tick();
    chk("stray_wr_count", 32'(n_wr), 0);
    chk("idle_busy", 32'(o_busy), 0);

    // Prime column 0 into bank 0.
    q_req.push_back(0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("prime_busy", 32'(o_busy), 1);
    chk("prime_stall", 32'(o_stall), 1);
    chk("prime_req", 32'(o_refill_req), 1);
    chk("prime_col", 32'(o_refill_col), 0);
    grant(3);
    q_req.push_back(1);
    fill(0, 0, 0, 64);
    chk("run_stall", 32'(o_stall), 0);
    chk("run_req_col1", 32'(o_refill_req), 1);
    chk("run_col1", 32'(o_refill_col), 1);

    // Fill column 1 into bank 1, then stream bank 0 with wrap.
    grant(0);
    fill(1, 1, 0, 64);
    rd(65, 0, 0);
    q_req.push_back(2);
    i_col_done = 1'b1;
    tick();
    i_col_done = 1'b0;
    chk("swap_stall", 32'(o_stall), 0);
    rd(1, 1, 0);

    // start in RUN is ignored.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_ign_stall", 32'(o_stall), 0);
    chk("start_ign_busy", 32'(o_busy), 1);

    // Starvation with a change_ref/col_done collision.
    grant(0);
    fill(2, 0, 0, 10);
    rd(2, 1, 1);
    i_col_done   = 1'b1;
    i_change_ref = 1'b1;
    tick();
    i_col_done   = 1'b0;
    i_change_ref = 1'b0;
    chk("starve_stall", 32'(o_stall), 1);
    i_change_ref = 1'b1;
    tick();
    i_change_ref = 1'b0;
    chk("starve_stall2", 32'(o_stall), 1);
    q_req.push_back(3);
    fill(2, 0, 10, 53);
    chk("starve_pre_last", 32'(o_stall), 1);
    fill(2, 0, 63, 1);
    chk("starve_released", 32'(o_stall), 0);
    rd(1, 0, 0);

    // Last beat coincides with col_done: swap without stall.
    grant(0);
    fill(3, 1, 0, 63);
    i_col_done = 1'b1;
    fill(3, 1, 63, 1);
    i_col_done = 1'b0;
    chk("coinc_stall", 32'(o_stall), 0);
    chk("coinc_busy", 32'(o_busy), 1);
    rd(1, 1, 0);

    // Last column consumed.
    i_col_done = 1'b1;
    tick();
    i_col_done = 1'b0;
    chk("done_pulse", 32'(o_done), 1);
    chk("done_busy", 32'(o_busy), 1);
    tick();
    chk("done_fall", 32'(o_done), 0);
    chk("idle_busy_after", 32'(o_busy), 0);
    chk("done_count", 32'(n_done), 1);
    chk("req_total_win1", 32'(n_req), 4);

    // Reset in the middle of RUN with beats still arriving.
    q_req.push_back(0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    grant(2);
    q_req.push_back(1);
    fill(0, 0, 0, 64);
    grant(0);
    fill(1, 1, 0, 20);
    rd(3, 0, 0);
    tick();
    i_refill_valid = 1'b1;
    i_refill_data  = mk(1, 20);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    i_refill_valid = 1'b0;
    tick();
    chk("post_rst_busy", 32'(o_busy), 0);
    chk("post_rst_req", 32'(o_refill_req), 0);
    chk("req_total", 32'(n_req), 6);
    chk("done_count_final", 32'(n_done), 1);

    chk("q_wr_empty", 32'(q_wr.size()), 0);
    chk("q_rd_empty", 32'(q_rd.size()), 0);
    chk("q_req_empty", 32'(q_req.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
